wb_timeout: RTL and testbench

//  Wishbone bus watchdog; sits directly downstream of the wb_arbiter_N slave port, in front of the shared slave/interconnect.

---
 rtl/wb_timeout_if.sv | 23 ++
 rtl/wb_timeout.sv | 108 ++++++++++
 tb/tb_wb_timeout.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/wb_timeout_if.sv
// Wishbone bus bundle shared by the watchdog's upstream and downstream sides.
// dat_w travels master->slave, dat_r travels slave->master.
interface wb_timeout_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH/8
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    we;
  logic [SELECT_WIDTH-1:0] sel;
  logic                    stb;
  logic                    cyc;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (output adr, dat_w, we, sel, stb, cyc,
                  input  dat_r, ack, err, rty);
  modport slave  (input  adr, dat_w, we, sel, stb, cyc,
                  output dat_r, ack, err, rty);
endinterface

// File: rtl/wb_timeout.sv
// Wishbone watchdog. Forwards the arbiter's granted cycle to the slave with
// zero latency, counts consecutive stalled strobe cycles and, once TIMEOUT
// of them have elapsed, spends one TERM cycle returning err upstream while
// dropping cyc/stb downstream so the slave abandons the access.
module wb_timeout #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH/8,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_timeout_if.slave           wbm,
  wb_timeout_if.master          wbs,
  input  logic                  enable,
  input  logic                  status_clr,
  output logic                  timeout_o,
  output logic [CNT_WIDTH-1:0]  timeout_count_o,
  output logic [ADDR_WIDTH-1:0] timeout_adr_o
);

  // Bits needed to hold 0..TIMEOUT-1 (at least one).
  function automatic int cnt_bits(input int t);
    int w;
    w = 1;
    while ((1 << w) < t) w++;
    return w;
  endfunction

  localparam int CW = cnt_bits(TIMEOUT);

  typedef enum logic {PASS, TERM} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            capture;
  logic            resp, stall;

  assign resp  = wbs.ack | wbs.err | wbs.rty;
  assign stall = enable & wbm.cyc & wbm.stb & ~resp;

  // Read data is never gated; the master only samples it with ack.
  assign wbm.dat_r = wbs.dat_r;

  // Next-state, stall counter and bus muxing; PASS forwards, TERM aborts.
  always_comb begin
    state_nxt = PASS;
    cnt_nxt   = '0;
    capture   = 1'b0;
    timeout_o = 1'b0;
    wbs.adr   = wbm.adr;
    wbs.dat_w = wbm.dat_w;
    wbs.we    = wbm.we;
    wbs.sel   = wbm.sel;
    wbs.stb   = wbm.stb;
    wbs.cyc   = wbm.cyc;
    wbm.ack   = wbs.ack & wbm.cyc;
    wbm.err   = wbs.err & wbm.cyc;
    wbm.rty   = wbs.rty & wbm.cyc;
    if (state == TERM) begin
      // Any late slave response is swallowed; the master sees only err.
      wbs.cyc   = 1'b0;
      wbs.stb   = 1'b0;
      wbm.ack   = 1'b0;
      wbm.err   = 1'b1;
      wbm.rty   = 1'b0;
      timeout_o = 1'b1;
    end else if (stall) begin
      if (cnt == CW'(TIMEOUT-1)) begin
        state_nxt = TERM;
        capture   = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // State and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PASS;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sticky status: saturating timeout count and address of the last victim.
  // A clear landing on the TERM cycle still leaves the fresh address visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_count_o <= '0;
      timeout_adr_o   <= '0;
    end else begin
      if (status_clr)
        timeout_count_o <= '0;
      else if (state == TERM && !(&timeout_count_o))
        timeout_count_o <= timeout_count_o + 1'b1;
      if (capture)
        timeout_adr_o <= wbm.adr;
      else if (status_clr && state != TERM)
        timeout_adr_o <= '0;
    end
  end

endmodule

// File: tb/tb_wb_timeout.sv
// Directed bench for wb_timeout: a per-cycle vector table on a TIMEOUT=4,
// CNT_WIDTH=2 instance, plus hand sequences for the long disabled stall,
// data/address pass-through and a TIMEOUT=1 instance.
module tb_wb_timeout;

  logic clk, rst;
  logic en0, clr0, tmo0;
  logic [1:0]  cnt0;
  logic [31:0] tadr0;
  logic en1, clr1, tmo1;
  logic [3:0]  cnt1;
  logic [31:0] tadr1;

  int checks = 0;
  int errors = 0;

  wb_timeout_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m0 ();
  wb_timeout_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s0 ();
  wb_timeout_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m1 ();
  wb_timeout_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s1 ();

  wb_timeout #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4), .CNT_WIDTH(2)) dut0 (
    .clk(clk), .rst(rst), .wbm(m0), .wbs(s0), .enable(en0), .status_clr(clr0),
    .timeout_o(tmo0), .timeout_count_o(cnt0), .timeout_adr_o(tadr0));

  wb_timeout #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(1), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .wbm(m1), .wbs(s1), .enable(en1), .status_clr(clr1),
    .timeout_o(tmo1), .timeout_count_o(cnt1), .timeout_adr_o(tadr1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, clr, cyc, stb;
    logic [31:0] adr;
    logic        ack, err, rty;
    logic        e_ack, e_err, e_rty, e_scyc, e_sstb, e_tmo;
    logic [1:0]  e_cnt;
    logic [31:0] e_tadr;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic r, logic en, logic clr, logic cyc, logic stb, logic [31:0] adr,
                              logic ack, logic err, logic rty,
                              logic ea, logic ee, logic er, logic esc, logic ess, logic et,
                              logic [1:0] ec, logic [31:0] eadr);
    vec_t v;
    v.rst = r; v.en = en; v.clr = clr; v.cyc = cyc; v.stb = stb; v.adr = adr;
    v.ack = ack; v.err = err; v.rty = rty;
    v.e_ack = ea; v.e_err = ee; v.e_rty = er; v.e_scyc = esc; v.e_sstb = ess; v.e_tmo = et;
    v.e_cnt = ec; v.e_tadr = eadr;
    vq.push_back(v);
  endfunction

  function automatic void idle(logic [1:0] c, logic [31:0] ta, logic clr = 1'b0);
    add(0, 1, clr, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c, ta);
  endfunction

  function automatic void stl(logic [31:0] a, int n, logic [1:0] c, logic [31:0] ta);
    for (int k = 0; k < n; k++) add(0, 1, 0, 1, 1, a, 0, 0, 0, 0, 0, 0, 1, 1, 0, c, ta);
  endfunction

  function automatic void ackr(logic [31:0] a, logic [1:0] c, logic [31:0] ta);
    add(0, 1, 0, 1, 1, a, 1, 0, 0, 1, 0, 0, 1, 1, 0, c, ta);
  endfunction

  function automatic void trm(logic [31:0] a, logic [1:0] c, logic [31:0] ta,
                              logic ack, logic clr, logic r);
    add(r, 1, clr, 1, 1, a, ack, 0, 0, 0, 1, 0, 0, 0, 1, c, ta);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive0(vec_t v);
    rst    = v.rst;
    en0    = v.en;
    clr0   = v.clr;
    m0.cyc = v.cyc;
    m0.stb = v.stb;
    m0.adr = v.adr;
    s0.ack = v.ack;
    s0.err = v.err;
    s0.rty = v.rty;
  endtask

  initial begin
    logic [39:0] act, exp;
    int bad;
    rst = 1'b1; en0 = 1'b1; clr0 = 1'b0; en1 = 1'b1; clr1 = 1'b0;
    m0.adr = '0; m0.dat_w = '0; m0.we = 1'b0; m0.sel = '1; m0.stb = 1'b0; m0.cyc = 1'b0;
    s0.dat_r = '0; s0.ack = 1'b0; s0.err = 1'b0; s0.rty = 1'b0;
    m1.adr = '0; m1.dat_w = '0; m1.we = 1'b0; m1.sel = '1; m1.stb = 1'b0; m1.cyc = 1'b0;
    s1.dat_r = '0; s1.ack = 1'b0; s1.err = 1'b0; s1.rty = 1'b0;

    // Case 1: read acked in cycle 2
    stl(32'h10, 2, 0, 0); ackr(32'h10, 0, 0); idle(0, 0);
    // Case 2: never answered -> TERM in cycle 4
    stl(32'h1000, 4, 0, 0); trm(32'h1000, 0, 32'h1000, 0, 0, 0); idle(1, 32'h1000);
    // Case 3a: ack in cycle 3 still forwarded
    stl(32'h20, 3, 1, 32'h1000); ackr(32'h20, 1, 32'h1000); idle(1, 32'h1000);
    // Case 3b: ack in cycle 4 masked by TERM
    stl(32'h30, 4, 1, 32'h1000); trm(32'h30, 1, 32'h30, 1, 0, 0); idle(2, 32'h30);
    // Slave err/rty pass-through, ack masked when cyc low
    add(0, 1, 0, 1, 1, 32'h40, 0, 1, 0, 0, 1, 0, 1, 1, 0, 2, 32'h30);
    add(0, 1, 0, 1, 1, 32'h40, 0, 0, 1, 0, 0, 1, 1, 1, 0, 2, 32'h30);
    add(0, 1, 0, 0, 0, 32'h40, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 32'h30);
    // cyc dropped before timeout restarts the count
    stl(32'h50, 3, 2, 32'h30); idle(2, 32'h30); stl(32'h50, 3, 2, 32'h30); ackr(32'h50, 2, 32'h30);
    // enable low for one cycle mid-stall restarts the count
    stl(32'h58, 3, 2, 32'h30);
    add(0, 0, 0, 1, 1, 32'h58, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 32'h30);
    stl(32'h58, 3, 2, 32'h30); ackr(32'h58, 2, 32'h30);
    // Count saturation then clear
    stl(32'h60, 4, 2, 32'h30); trm(32'h60, 2, 32'h60, 0, 0, 0); idle(3, 32'h60);
    stl(32'h70, 4, 3, 32'h60); trm(32'h70, 3, 32'h70, 0, 0, 0); idle(3, 32'h70);
    idle(3, 32'h70, 1'b1); idle(0, 0);
    // Clear coinciding with TERM: count 0, address kept
    stl(32'h80, 4, 0, 0); trm(32'h80, 0, 32'h80, 0, 1, 0); idle(0, 32'h80);
    // Reset at cnt=2: a full TIMEOUT is needed afterwards
    stl(32'h90, 2, 0, 32'h80);
    add(1, 1, 0, 1, 1, 32'h90, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h80);
    stl(32'h90, 4, 0, 0); trm(32'h90, 0, 32'h90, 0, 0, 0); idle(1, 32'h90);
    // Reset during TERM: no err afterwards
    stl(32'hA0, 4, 1, 32'h90); trm(32'hA0, 1, 32'hA0, 0, 0, 1); idle(0, 0);
    // Master holds cyc and re-strobes after TERM: fresh access
    stl(32'hB0, 4, 0, 0); trm(32'hB0, 0, 32'hB0, 0, 0, 0);
    stl(32'hB0, 3, 1, 32'hB0); ackr(32'hB0, 1, 32'hB0);
    // Four back-to-back strobes, each stalled 3 cycles then acked
    for (int k = 0; k < 4; k++) begin
      stl(32'hB4 + k, 3, 1, 32'hB0); ackr(32'hB4 + k, 1, 32'hB0);
    end
    idle(1, 32'hB0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {62'h0, tmo0, m0.err} | {cnt0, tadr0, 30'h0}, 64'h0);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive0(vq[i]);
      @(negedge clk);
      act = {m0.ack, m0.err, m0.rty, s0.cyc, s0.stb, tmo0, cnt0, tadr0};
      exp = {vq[i].e_ack, vq[i].e_err, vq[i].e_rty, vq[i].e_scyc, vq[i].e_sstb,
             vq[i].e_tmo, vq[i].e_cnt, vq[i].e_tadr};
      chk($sformatf("row%0d", i), 64'(act), 64'(exp));
    end

    // enable=0: 100 stalled cycles then ack, no timeout
    @(posedge clk); #1;
    en0 = 1'b0; m0.cyc = 1'b1; m0.stb = 1'b1; m0.adr = 32'hD0;
    m0.dat_w = 32'h1234_5678; m0.we = 1'b1; s0.dat_r = 32'hDEAD_BEEF;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m0.err !== 1'b0 || tmo0 !== 1'b0 || s0.cyc !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    chk("en0 stall no err", 64'(bad), 64'd0);
    chk("pass dat_r", 64'(m0.dat_r), 64'hDEAD_BEEF);
    chk("pass dat_w/adr/we", {s0.dat_w, s0.adr[30:0], s0.we}, {32'h1234_5678, 31'hD0, 1'b1});
    s0.ack = 1'b1;
    @(negedge clk);
    chk("en0 ack forwarded", {m0.ack, m0.err}, 2'b10);
    @(posedge clk); #1;
    s0.ack = 1'b0; m0.cyc = 1'b0; m0.stb = 1'b0; en0 = 1'b1;
    @(negedge clk);
    chk("en0 count unchanged", {cnt0, tadr0}, {2'd1, 32'hB0});

    // TIMEOUT=1: unanswered strobe terminates the next cycle
    @(posedge clk); #1;
    m1.cyc = 1'b1; m1.stb = 1'b1; m1.adr = 32'hC0;
    @(negedge clk);
    chk("t1 cycle0", {m1.err, tmo1, s1.cyc}, 3'b001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1 term", {m1.err, tmo1, s1.cyc, s1.stb}, 4'b1100);
    @(posedge clk); #1;
    s1.ack = 1'b1;
    @(negedge clk);
    chk("t1 same-cycle ack", {m1.ack, m1.err, tmo1}, 3'b100);
    @(posedge clk); #1;
    s1.ack = 1'b0; m1.cyc = 1'b0; m1.stb = 1'b0;
    @(negedge clk);
    chk("t1 status", {m1.err, tmo1, cnt1, tadr1}, {2'b00, 4'd1, 32'hC0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
